mem_subsystem: RTL

MEM_SUBSYSTEM -- requirements
Module: mem_subsystem

---
 rtl/mem_subsystem_if.sv | 27 ++
 rtl/mem_subsystem.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_subsystem_if.sv
// Instruction-fetch and data-access ports of mem_subsystem (master = requester, slave = memory).
interface mem_subsystem_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_strb;
    logic              d_ready;
    logic [31:0]       d_rdata;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_strb,
        input  i_ready, i_rdata, d_ready, d_rdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_strb,
        output i_ready, i_rdata, d_ready, d_rdata
    );
endinterface

// File: rtl/mem_subsystem.sv
// Single-ported memory shared by fetch and data ports, with wait-state FSM and starvation-limited arbitration.
// Byte-lane writes are enabled by defining MEM_BYTE_STROBE_EN; otherwise every write stores the full word.
module mem_subsystem #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic           Clk,
    input  logic           Reset,
    mem_subsystem_if.slave bus,
    output logic           busy
);
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
`ifdef MEM_BYTE_STROBE_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt;
    logic [1:0]        loss_cnt, loss_cnt_nxt;
    logic              grant_d, grant_d_nxt;
    logic              we, we_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [31:0]       wdata, wdata_nxt;
    logic [3:0]        strb, strb_nxt;
    logic [ADDR_W-1:0] sel_addr;
    logic              access;
    logic [31:0]       lane_mask;
    logic [31:0]       cur_word;
    logic [31:0]       new_word;

    logic [31:0] mem [DEPTH_WORDS];

    // Next-state and transaction latching
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        loss_cnt_nxt = loss_cnt;
        grant_d_nxt  = grant_d;
        we_nxt       = we;
        idx_nxt      = idx;
        wdata_nxt    = wdata;
        strb_nxt     = strb;
        sel_addr     = bus.i_addr;
        case (state)
            S_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // Data wins ties unless the fetch port has already lost twice in a row
                    grant_d_nxt  = bus.d_req && !(bus.i_req && loss_cnt == 2'd2);
                    loss_cnt_nxt = grant_d_nxt ? loss_cnt + 2'(bus.i_req) : 2'd0;
                    sel_addr     = grant_d_nxt ? bus.d_addr : bus.i_addr;
                    idx_nxt      = sel_addr[IDX_W+1:2];
                    we_nxt       = grant_d_nxt && bus.d_we;
                    wdata_nxt    = bus.d_wdata;
                    strb_nxt     = bus.d_strb;
                    wait_cnt_nxt = WAIT_INIT;
                    state_nxt    = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The array is accessed on the edge entering DONE so data is presented during DONE
    assign access    = (state_nxt == S_DONE) && !Reset;
    assign cur_word  = mem[idx_nxt];
    assign lane_mask = STRB_EN ? {{8{strb_nxt[3]}}, {8{strb_nxt[2]}}, {8{strb_nxt[1]}}, {8{strb_nxt[0]}}}
                               : 32'hFFFF_FFFF;
    assign new_word  = (cur_word & ~lane_mask) | (wdata_nxt & lane_mask);

    always_ff @(posedge Clk) begin
        if (access && we_nxt) begin
            mem[idx_nxt] <= new_word;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            loss_cnt <= 2'd0;
            grant_d  <= 1'b0;
            we       <= 1'b0;
            idx      <= '0;
            wdata    <= 32'd0;
            strb     <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            loss_cnt <= loss_cnt_nxt;
            grant_d  <= grant_d_nxt;
            we       <= we_nxt;
            idx      <= idx_nxt;
            wdata    <= wdata_nxt;
            strb     <= strb_nxt;
        end
    end

    // Registered handshake outputs; read data holds between pulses
    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy        <= 1'b0;
            bus.i_ready <= 1'b0;
            bus.d_ready <= 1'b0;
            bus.i_rdata <= 32'd0;
            bus.d_rdata <= 32'd0;
        end else begin
            busy        <= (state_nxt != S_IDLE);
            bus.i_ready <= access && !grant_d_nxt;
            bus.d_ready <= access && grant_d_nxt;
            if (access && !grant_d_nxt) begin
                bus.i_rdata <= cur_word;
            end
            if (access && grant_d_nxt) begin
                bus.d_rdata <= we_nxt ? new_word : cur_word;
            end
        end
    end
endmodule
